// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared states and frame constants for demux_frame_rx (DEMUX_FRAME_PARITY_EN adds the parity bit)
package demux_pkg;

  localparam int SEL_W      = 3;
  localparam int ADDR_BITS  = 3;
  localparam int START_BITS = 1;
  localparam int DATA_BITS  = 1;
`ifdef DEMUX_FRAME_PARITY_EN
  localparam int PAR_BITS   = 1;
`else
  localparam int PAR_BITS   = 0;
`endif
  localparam int FRAME_LEN  = START_BITS + ADDR_BITS + DATA_BITS + PAR_BITS;

  // Idle-gap counter width; covers the full 1..255 timeout range.
  localparam int TIMER_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
`ifdef DEMUX_FRAME_PARITY_EN
    ,
    ST_PAR  = 2'd3
`endif
  } state_e;

`ifdef DEMUX_FRAME_PARITY_EN
  // Returns 1 when the word holds an odd number of ones (frame rejected).
  function automatic logic odd_parity(input logic [ADDR_BITS+1:0] bits);
    return ^bits;
  endfunction
`endif

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - consecutive idle-cycle counter that flags an in-frame timeout
module frame_timer
  import demux_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(IDLE_TIMEOUT - 1);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  // The tick that would make the count reach IDLE_TIMEOUT is the expiring one;
  // a clear in that same cycle (accepted bit) wins and suppresses the timeout.
  assign expired = tick && !clear && (cnt_q == LIMIT);

  // Next count: restart on clear, otherwise advance on each idle tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/demux_frame_rx.sv
// rtl/demux_frame_rx.sv - serial frame receiver driving a 1-to-8 demux (DEMUX_FRAME_PARITY_EN enables parity check)
module demux_frame_rx
  import demux_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_vld,
  output logic [SEL_W-1:0] sel,
  output logic             din,
  output logic             strobe,
  output logic             busy,
  output logic             err
);

  localparam logic [1:0] ADDR_LAST = 2'(ADDR_BITS - 1);

  state_e               state_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [1:0]           bit_cnt_q;
  logic [SEL_W-1:0]     sel_q;
  logic                 din_q;
  logic                 strobe_q;
  logic                 busy_q;
  logic                 err_q;
`ifdef DEMUX_FRAME_PARITY_EN
  logic                 data_q;
`endif

  logic in_frame;
  logic timer_tick;
  logic timer_clear;
  logic timeout;

  // Idle gaps only count while a frame is open; any accepted bit restarts the gap.
  assign in_frame    = (state_q != ST_IDLE);
  assign timer_tick  = in_frame && !ser_vld;
  assign timer_clear = !in_frame || ser_vld;

  frame_timer #(
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .tick   (timer_tick),
    .expired(timeout)
  );

  // Frame FSM with registered demux outputs; strobe/err default to a one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      bit_cnt_q <= '0;
      sel_q     <= '0;
      din_q     <= 1'b0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef DEMUX_FRAME_PARITY_EN
      data_q    <= 1'b0;
`endif
    end else begin
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      if (in_frame && timeout) begin
        // Abandon the partial frame; sel/din keep their last committed values.
        state_q   <= ST_IDLE;
        busy_q    <= 1'b0;
        bit_cnt_q <= '0;
        err_q     <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            // Only a qualified 1 opens a frame; qualified zeros are line noise.
            if (ser_vld && ser_in) begin
              state_q   <= ST_ADDR;
              busy_q    <= 1'b1;
              bit_cnt_q <= '0;
            end
          end
          ST_ADDR: begin
            if (ser_vld) begin
              addr_q <= {addr_q[ADDR_BITS-2:0], ser_in};
              if (bit_cnt_q == ADDR_LAST) begin
                bit_cnt_q <= '0;
                state_q   <= ST_DATA;
              end else begin
                bit_cnt_q <= bit_cnt_q + 2'd1;
              end
            end
          end
          ST_DATA: begin
            if (ser_vld) begin
`ifdef DEMUX_FRAME_PARITY_EN
              data_q  <= ser_in;
              state_q <= ST_PAR;
`else
              sel_q    <= addr_q;
              din_q    <= ser_in;
              strobe_q <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= ST_IDLE;
`endif
            end
          end
`ifdef DEMUX_FRAME_PARITY_EN
          ST_PAR: begin
            if (ser_vld) begin
              if (!odd_parity({addr_q, data_q, ser_in})) begin
                sel_q    <= addr_q;
                din_q    <= data_q;
                strobe_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
`endif
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sel    = sel_q;
  assign din    = din_q;
  assign strobe = strobe_q;
  assign busy   = busy_q;
  assign err    = err_q;

endmodule

// File: tb/tb_demux_frame_rx.sv
// tb/tb_demux_frame_rx.sv - randomized self-checking bench for demux_frame_rx against a bit-list frame model
module tb_demux_frame_rx;

  localparam int TO = 15;
`ifdef DEMUX_FRAME_PARITY_EN
  localparam int FLEN = 6;
`else
  localparam int FLEN = 5;
`endif

  logic       clk;
  logic       rst;
  logic       ser_in;
  logic       ser_vld;
  logic [2:0] sel;
  logic       din;
  logic       strobe;
  logic       busy;
  logic       err;

  int n_pass;
  int n_total;

  // Model state: the frame is kept as the list of accepted bits packed into a word.
  bit         m_in_frame;
  int         m_nbits;
  int         m_gap;
  logic [7:0] m_frame;
  logic [2:0] exp_sel;
  logic       exp_din;
  logic       exp_strobe;
  logic       exp_err;
  logic       exp_busy;

  demux_frame_rx #(
    .IDLE_TIMEOUT(TO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ser_in (ser_in),
    .ser_vld(ser_vld),
    .sel    (sel),
    .din    (din),
    .strobe (strobe),
    .busy   (busy),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 1'b0;
    m_nbits    = 0;
    m_gap      = 0;
    m_frame    = '0;
    exp_sel    = '0;
    exp_din    = 1'b0;
    exp_strobe = 1'b0;
    exp_err    = 1'b0;
    exp_busy   = 1'b0;
  endtask

  // One clock edge of the frame rules: collect bits, decode a full frame, or age the gap.
  task automatic model_step(input logic v, input logic b);
    exp_strobe = 1'b0;
    exp_err    = 1'b0;
    if (!m_in_frame) begin
      if (v && b) begin
        m_in_frame = 1'b1;
        m_frame    = 8'd1;
        m_nbits    = 1;
        m_gap      = 0;
      end
    end else if (v) begin
      m_frame = {m_frame[6:0], b};
      m_nbits++;
      m_gap = 0;
      if (m_nbits == FLEN) begin
        m_in_frame = 1'b0;
`ifdef DEMUX_FRAME_PARITY_EN
        if ((^m_frame[4:0]) == 1'b0) begin
          exp_sel    = m_frame[4:2];
          exp_din    = m_frame[1];
          exp_strobe = 1'b1;
        end else begin
          exp_err = 1'b1;
        end
`else
        exp_sel    = m_frame[3:1];
        exp_din    = m_frame[0];
        exp_strobe = 1'b1;
`endif
      end
    end else begin
      m_gap++;
      if (m_gap == TO) begin
        m_in_frame = 1'b0;
        exp_err    = 1'b1;
      end
    end
    exp_busy = m_in_frame;
  endtask

  // Compare process: advance the model on each edge and check every output just after it.
  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      model_step(ser_vld, ser_in);
      #1;
      chk("sel", 8'(sel), 8'(exp_sel));
      chk("din", 8'(din), 8'(exp_din));
      chk("strobe", 8'(strobe), 8'(exp_strobe));
      chk("busy", 8'(busy), 8'(exp_busy));
      chk("err", 8'(err), 8'(exp_err));
    end
  end

  // Apply inputs at a falling edge and return at the next falling edge.
  task automatic drive(input logic v, input logic b);
    ser_vld = v;
    ser_in  = b;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [2:0] a, input logic d, input int gap_before_data);
    logic [2:0] av;
    av = a;
    drive(1'b1, 1'b1);
    for (int i = 2; i >= 0; i--) drive(1'b1, av[i]);
    repeat (gap_before_data) drive(1'b0, 1'b0);
    drive(1'b1, d);
`ifdef DEMUX_FRAME_PARITY_EN
    drive(1'b1, ^{av, d});
`endif
  endtask

  initial begin
    logic [7:0] bits;
    int         nb;
    int         r;
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    ser_vld = 1'b0;
    ser_in  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_sel", 8'(sel), 8'h00);
    chk("reset_din", 8'(din), 8'h00);
    chk("reset_busy", 8'(busy), 8'h00);
    chk("reset_strobe", 8'(strobe), 8'h00);
    chk("reset_err", 8'(err), 8'h00);
    rst = 1'b0;

    // Basic frame: address 101, data 1.
    send_frame(3'b101, 1'b1, 0);
    chk("f1_strobe", 8'(strobe), 8'h01);
    chk("f1_sel", 8'(sel), 8'h05);
    chk("f1_din", 8'(din), 8'h01);
    drive(1'b0, 1'b0);
    chk("f1_strobe_end", 8'(strobe), 8'h00);
    chk("f1_busy_after", 8'(busy), 8'h00);

    // Idle-line noise never opens a frame.
    repeat (10) drive(1'b1, 1'b0);
    chk("noise_busy", 8'(busy), 8'h00);
    chk("noise_sel", 8'(sel), 8'h05);

    // Start plus two address bits, then a full timeout gap.
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    chk("to_busy", 8'(busy), 8'h01);
    repeat (TO - 1) drive(1'b0, 1'b0);
    chk("to_no_err_early", 8'(err), 8'h00);
    drive(1'b0, 1'b0);
    chk("to_err", 8'(err), 8'h01);
    chk("to_busy_low", 8'(busy), 8'h00);
    chk("to_sel_kept", 8'(sel), 8'h05);
    chk("to_din_kept", 8'(din), 8'h01);
    drive(1'b0, 1'b0);
    chk("to_err_one_cycle", 8'(err), 8'h00);

    // A gap one short of the timeout, then the data bit lands in the would-be expiry cycle.
    send_frame(3'b010, 1'b1, TO - 1);
    chk("gap_strobe", 8'(strobe), 8'h01);
    chk("gap_sel", 8'(sel), 8'h02);
    chk("gap_err", 8'(err), 8'h00);

    // Back-to-back frames: next start bit sent while strobe is high.
    send_frame(3'b001, 1'b0, 0);
    chk("b2b_a_sel", 8'(sel), 8'h01);
    send_frame(3'b110, 1'b1, 0);
    chk("b2b_b_sel", 8'(sel), 8'h06);
    chk("b2b_b_strobe", 8'(strobe), 8'h01);
    drive(1'b0, 1'b0);

    // Reset mid-frame after the address bits of a sel=010 frame.
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_sel", 8'(sel), 8'h00);
    chk("rst_din", 8'(din), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0);
    chk("rst_no_strobe", 8'(strobe), 8'h00);
    chk("rst_no_err", 8'(err), 8'h00);
    repeat (3) drive(1'b0, 1'b0);

`ifdef DEMUX_FRAME_PARITY_EN
    // Parity: good frame loads, bad frame errors and leaves outputs alone.
    drive(1'b1, 1'b1); drive(1'b1, 1'b0); drive(1'b1, 1'b1); drive(1'b1, 1'b1);
    drive(1'b1, 1'b1); drive(1'b1, 1'b1);
    chk("par_ok_strobe", 8'(strobe), 8'h01);
    chk("par_ok_sel", 8'(sel), 8'h03);
    drive(1'b1, 1'b1); drive(1'b1, 1'b0); drive(1'b1, 1'b1); drive(1'b1, 1'b1);
    drive(1'b1, 1'b1); drive(1'b1, 1'b0);
    chk("par_bad_err", 8'(err), 8'h01);
    chk("par_bad_strobe", 8'(strobe), 8'h00);
    chk("par_bad_sel", 8'(sel), 8'h03);
    drive(1'b0, 1'b0);
`endif

    // Randomized frames with varied gaps, stray bits and occasional resets.
    for (int f = 0; f < 400; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 4)) drive(1'(($urandom_range(0, 3)) == 0), 1'b0);
      end
      bits    = 8'($urandom);
      bits[0] = 1'b1;
      nb      = FLEN;
      for (int i = 0; i < nb; i++) begin
        r = int'($urandom_range(0, 99));
        if (i > 0) begin
          if (r >= 90) begin
            repeat ($urandom_range(TO - 3, TO + 2)) drive(1'b0, 1'($urandom));
          end else if (r >= 70) begin
            repeat ($urandom_range(1, 4)) drive(1'b0, 1'($urandom));
          end
        end
        drive(1'b1, bits[i]);
        if (i == 2 && $urandom_range(0, 49) == 0) begin
          #2;
          rst = 1'b1;
          model_reset();
          @(negedge clk);
          rst = 1'b0;
        end
      end
    end
    repeat (TO + 5) drive(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
